// File: rtl/mod_audio_pkg.sv
// Shared audio types for the I2S transmit path: sample widths, stereo word layout, FSM states.
// No logic, no latency; types only.
package mod_audio_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 64;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_sample_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mod_sample_fifo.sv
// Synchronous sample FIFO; pop_dat is the head entry with zero read latency.
// Pushes while full and pops while empty are ignored; the caller uses full/empty as its flow control.
module mod_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign wr_en   = push && !full;
  assign rd_en   = pop && !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_i2s_tx.sv
// I2S transmitter: buffers stereo words and serialises them with self-generated BCLK/LRCK, one word per 64-bit frame.
// A word is loaded at the start of the frame after it is queued; o_ready drops only while the FIFO is full.
module mod_i2s_tx #(
  parameter int BCLK_HALF  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRIME      = 2
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic [31:0]                   i_sample,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_bclk,
  output logic                          o_lrck,
  output logic                          o_dacdat,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic [15:0]                   o_underrun_cnt
);

  import mod_audio_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int KW = $clog2(FRAME_BITS);

  logic [CW-1:0]  div_cnt;
  logic           div_wrap;
  logic           fall_tick;
  logic [KW-1:0]  k;
  logic [KW-1:0]  k_nxt;
  logic [KW-2:0]  s_nxt;
  logic           frame_end;
  logic           slot_data;

  state_t         state;
  state_t         state_nxt;
  logic           load;
  logic           pop;
  logic           underrun_inc;
  logic           shift_en;

  logic           push;
  logic           fifo_full;
  logic           fifo_empty;
  stereo_sample_t fifo_word;
  stereo_sample_t sr;

  assign push    = i_valid && !fifo_full;
  assign o_ready = !fifo_full;

  mod_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*SAMPLE_W)
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_nrst),
    .push     (push),
    .push_dat (i_sample),
    .pop      (pop),
    .pop_dat  (fifo_word),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (o_level)
  );

  assign div_wrap  = (div_cnt == CW'(BCLK_HALF-1));
  assign fall_tick = div_wrap && o_bclk;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      div_cnt <= '0;
      o_bclk  <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      o_bclk  <= o_bclk ^ div_wrap;
    end
  end

  // Every serial output is retimed from k_nxt so it moves exactly on the BCLK falling edge.
  assign k_nxt     = k + 1'b1;
  assign s_nxt     = k_nxt[KW-2:0];
  assign frame_end = fall_tick && (k == KW'(FRAME_BITS-1));
  assign slot_data = (s_nxt != '0) && (s_nxt <= (KW-1)'(SAMPLE_W));

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      k <= KW'(FRAME_BITS-1);
    end else if (fall_tick) begin
      k <= k_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_IDLE && frame_end && (o_level >= LW'(PRIME))) begin
      state_nxt = ST_RUN;
    end
  end

  // Load decisions use pre-push occupancy, so a word arriving on a load edge waits for the next frame.
  always_comb begin
    load         = frame_end && (state_nxt == ST_RUN);
    pop          = load && !fifo_empty;
    underrun_inc = load && fifo_empty;
    shift_en     = fall_tick && (state == ST_RUN) && slot_data;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sr       <= '0;
      o_lrck   <= 1'b0;
      o_dacdat <= 1'b0;
    end else if (fall_tick) begin
      o_lrck   <= k_nxt[KW-1];
      o_dacdat <= shift_en ? sr[2*SAMPLE_W-1] : 1'b0;
      if (load) begin
        sr <= pop ? fifo_word : '0;
      end else if (shift_en) begin
        sr <= {sr[2*SAMPLE_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_underrun_cnt <= '0;
    end else if (underrun_inc && (o_underrun_cnt != 16'hFFFF)) begin
      o_underrun_cnt <= o_underrun_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mod_i2s_tx.sv
// Directed bench for mod_i2s_tx: scoreboard of queued words compared against frames captured at BCLK rising edges.
// Covers reset, BCLK timing, framing, full FIFO, underrun, push-on-load and mid-frame reset.
module tb_mod_i2s_tx;

  logic        i_clk    = 1'b0;
  logic        i_nrst   = 1'b0;
  logic        i_valid  = 1'b0;
  logic [31:0] i_sample = '0;
  logic        o_ready;
  logic        o_bclk;
  logic        o_lrck;
  logic        o_dacdat;
  logic [2:0]  o_level;
  logic [15:0] o_underrun_cnt;

  mod_i2s_tx dut (
    .i_clk          (i_clk),
    .i_nrst         (i_nrst),
    .i_sample       (i_sample),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .o_bclk         (o_bclk),
    .o_lrck         (o_lrck),
    .o_dacdat       (o_dacdat),
    .o_level        (o_level),
    .o_underrun_cnt (o_underrun_cnt)
  );

  always #5 i_clk = ~i_clk;

  int          tests = 0;
  int          fails = 0;
  int          exp_under = 0;
  logic [31:0] sb [$];
  int          cyc;
  int          nstarts;
  logic [5:0]  k_model;
  logic        bclk_q;

  always @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Independent frame-position model driven only by observed BCLK falling edges.
  always @(negedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      k_model <= 6'd63;
      bclk_q  <= 1'b0;
      nstarts <= 0;
    end else begin
      bclk_q <= o_bclk;
      if (bclk_q && !o_bclk) begin
        k_model <= k_model + 6'd1;
        if (k_model == 6'd63) nstarts <= nstarts + 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_bclk"},   32'(o_bclk),         32'd0);
    check({tag, "_lrck"},   32'(o_lrck),         32'd0);
    check({tag, "_dacdat"}, 32'(o_dacdat),       32'd0);
    check({tag, "_level"},  32'(o_level),        32'd0);
    check({tag, "_under"},  32'(o_underrun_cnt), 32'd0);
    check({tag, "_ready"},  32'(o_ready),        32'd1);
  endtask

  task automatic wait_bclk(input logic lvl);
    int n = 0;
    while (o_bclk !== lvl && n < 64) begin
      @(negedge i_clk);
      n++;
    end
    if (o_bclk !== lvl) check("bclk_wait", 32'(o_bclk), 32'(lvl));
  endtask

  task automatic wait_frame_start();
    int s = nstarts;
    int n = 0;
    while (nstarts == s && n < 2200) begin
      @(negedge i_clk);
      n++;
    end
    if (nstarts == s) check("frame_wait", nstarts, s + 1);
  endtask

  task automatic wait_cyc(input int t);
    int n = 0;
    while (cyc < t && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    check("cyc_wait", cyc, t);
  endtask

  task automatic push_word(input logic [31:0] w);
    int n = 0;
    i_sample = w;
    i_valid  = 1'b1;
    while (o_ready !== 1'b1 && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    if (o_ready !== 1'b1) check("push_wait", 32'(o_ready), 32'd1);
    @(negedge i_clk);
    i_valid = 1'b0;
    sb.push_back(w);
  endtask

  // Entered in the low half of BCLK for k=0; returns at the next frame's k=0 fall.
  task automatic capture_frame(output logic [31:0] data, output int lr_err, output int pad_err);
    int s;
    data    = '0;
    lr_err  = 0;
    pad_err = 0;
    for (int k = 0; k < 64; k++) begin
      wait_bclk(1'b1);
      s = k % 32;
      if (o_lrck !== (k >= 32)) lr_err++;
      if (s >= 1 && s <= 16) data = {data[30:0], o_dacdat};
      else if (o_dacdat !== 1'b0) pad_err++;
      wait_bclk(1'b0);
    end
  endtask

  task automatic run_frame(input bit running, input string tag);
    logic [31:0] exp;
    logic [31:0] got;
    int          lr;
    int          pad;
    exp = '0;
    if (running) begin
      if (sb.size() > 0) exp = sb.pop_front();
      else exp_under++;
    end
    check({tag, "_level"}, 32'(o_level), sb.size());
    check({tag, "_under"}, 32'(o_underrun_cnt), exp_under);
    capture_frame(got, lr, pad);
    check({tag, "_data"}, got, exp);
    check({tag, "_lrck"}, lr, 0);
    check({tag, "_pad"},  pad, 0);
  endtask

  task automatic do_reset(input string tag);
    i_valid = 1'b0;
    i_nrst  = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset(tag);
    sb.delete();
    exp_under = 0;
    i_nrst = 1'b1;
  endtask

  initial begin
    logic [31:0] tmp;

    // Reset values and BCLK timing
    repeat (5) @(negedge i_clk);
    check_reset("rst");
    i_nrst = 1'b1;
    wait_bclk(1'b1);
    check("bclk_rise", cyc, 8);
    wait_bclk(1'b0);
    check("bclk_fall", cyc, 16);
    wait_bclk(1'b1);
    wait_bclk(1'b0);
    check("bclk_period", cyc, 32);

    // Basic frames followed by underrun
    push_word(32'hA5A50F0F);
    push_word(32'h80017FFE);
    wait_frame_start();
    run_frame(1'b1, "f1");
    run_frame(1'b1, "f2");
    run_frame(1'b1, "f3_under");
    run_frame(1'b1, "f4_under");

    // Full FIFO: fifth word held until the first pop
    do_reset("rst_full");
    push_word(32'h11112222);
    push_word(32'h33334444);
    push_word(32'h55556666);
    push_word(32'h77778888);
    check("full_ready", 32'(o_ready), 32'd0);
    check("full_level", 32'(o_level), 32'd4);
    i_sample = 32'h9999AAAA;
    i_valid  = 1'b1;
    for (int n = 0; n < 100 && o_ready !== 1'b1; n++) @(negedge i_clk);
    check("full_pop_cyc", cyc, 16);
    check("full_pop_level", 32'(o_level), 32'd3);
    @(negedge i_clk);
    i_valid = 1'b0;
    sb.push_back(32'h9999AAAA);
    check("full_refill_level", 32'(o_level), 32'd4);
    check("full_refill_ready", 32'(o_ready), 32'd0);
    run_frame(1'b1, "q1");
    run_frame(1'b1, "q2");
    run_frame(1'b1, "q3");
    run_frame(1'b1, "q4");
    run_frame(1'b1, "q5");
    run_frame(1'b1, "q6_under");

    // Push on the same edge as a frame load
    do_reset("rst_sim");
    push_word(32'hDEAD0001);
    push_word(32'hBEEF0002);
    wait_cyc(1039);
    tmp = sb.pop_front();
    check("sim_before_level", 32'(o_level), 32'd1);
    i_sample = 32'h0123FEDC;
    i_valid  = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    sb.push_back(32'h0123FEDC);
    check("sim_after_level", 32'(o_level), 32'd1);
    run_frame(1'b1, "s2");
    run_frame(1'b1, "s3");

    // Mid-frame reset, then re-prime
    do_reset("rst_mid_pre");
    push_word(tmp);
    push_word(32'h4444CCCC);
    wait_frame_start();
    for (int n = 0; n < 600 && !(k_model == 6'd20 && o_bclk === 1'b1); n++) @(negedge i_clk);
    check("mid_k", 32'(k_model), 32'd20);
    #2;
    i_nrst = 1'b0;
    #1;
    check_reset("mid_rst");
    sb.delete();
    exp_under = 0;
    repeat (3) @(negedge i_clk);
    i_nrst = 1'b1;
    push_word(32'h6B6B1234);
    wait_frame_start();
    run_frame(1'b0, "m_idle1");
    push_word(32'h8000FFFF);
    run_frame(1'b0, "m_idle2");
    run_frame(1'b1, "m_run1");
    run_frame(1'b1, "m_run2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mod_i2s_tx.md
Name: mod_i2s_tx

Overview:
Downstream stage of the synth driver. Accepts 32-bit stereo sample words {left[31:16], right[15:0]} through a valid/ready handshake and buffers them in a small FIFO. Serializes them to the audio codec DAC in standard I2S format. Generates BCLK and LRCK itself from the system clock, so the design has one clock domain.

Parameters:
BCLK_HALF, 8, system clocks per BCLK half-period (BCLK = i_clk / (2*BCLK_HALF)).
FIFO_DEPTH, 4, sample FIFO entries; power of two, >= 2.
PRIME, 2, FIFO occupancy required before leaving IDLE; 1..FIFO_DEPTH.

Ports:
i_clk  input  1  system clock
i_nrst  input  1  reset, asynchronous, active-low
i_sample  input  32  stereo word {L[31:16], R[15:0]}, two's complement
i_valid  input  1  i_sample valid
o_ready  output  1  FIFO can accept (= !full)
o_bclk  output  1  I2S bit clock
o_lrck  output  1  I2S word select; 0 = left
o_dacdat  output  1  I2S serial data
o_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
o_underrun_cnt  output  16  saturating count of frames with no sample available

Behaviour:
- Clock/reset: one clock, i_clk. Reset i_nrst is asynchronous, active-low.
- Reset values:
  - o_bclk=0, o_lrck=0, o_dacdat=0, o_level=0, o_underrun_cnt=0, o_ready=1.
  - FIFO flushed; state=IDLE; frame bit counter k=63.
  - Reset mid-frame aborts the frame immediately.
- BCLK divider:
  - Counter runs 0..BCLK_HALF-1; o_bclk toggles on wrap.
  - Runs in every state.
  - The cycle on which o_bclk goes 1->0 is the "fall tick".
- Frame:
  - 64 BCLK periods; k increments mod 64 on every fall tick. All serial outputs change only on fall ticks.
  - o_lrck = (k >= 32).
  - Slot position s = k mod 32.
  - o_dacdat = bit (15-(s-1)) of the current channel for s=1..16; 0 for s=0 and s=17..31.
  - Result: MSB appears one BCLK after the LRCK edge; the codec samples on BCLK rising.
- Handshake:
  - Push when i_valid && o_ready, one word per cycle.
  - i_sample must be held stable while i_valid && !o_ready.
  - No push is accepted while full.
- FSM (states in package enum):
  - IDLE: o_dacdat=0; o_bclk/o_lrck keep running. On the fall tick where k becomes 0 and o_level >= PRIME: go to RUN and load the frame.
  - RUN, on every fall tick where k becomes 0:
    - FIFO non-empty: pop into the 32-bit shift register.
    - FIFO empty: load 0 and increment o_underrun_cnt (saturates at 0xFFFF). Stay in RUN; no return to IDLE except by reset.
- Pop vs push:
  - Pop uses occupancy before any same-cycle push; no bypass. Push into an empty FIFO on a load cycle still counts as an underrun.
  - Simultaneous push and pop leaves o_level unchanged.
- Pointers wrap mod FIFO_DEPTH; occupancy is tracked with an extra bit.
- Throughput: one sample per 128*BCLK_HALF clocks (1024 at default; 48.8 kHz at 50 MHz).

Decomposition:
- Package mod_audio_pkg holds:
  - SAMPLE_W=16 and FRAME_BITS=64
  - typedef stereo_sample_t (packed struct {left, right})
  - state enum {ST_IDLE, ST_RUN}
- Sub-module mod_sample_fifo:
  - Parameterised synchronous FIFO (DEPTH, WIDTH=32)
  - Push/pop, full/empty, level outputs; async active-low reset
- The top holds the BCLK divider, frame counter, FSM, shift register and underrun counter.

Test Plan:
- Reset: hold i_nrst=0 for 5 clocks -> all outputs at reset values, o_ready=1, o_level=0. Release -> o_bclk first rises at clock 8, falls at clock 16, period 16 clocks.
- Basic frame: push 0xA5A50F0F and 0x80017FFE -> IDLE ends at the next k=0 fall tick.
  - Left slot: bits on s=1..16 read 0xA5A5 MSB-first at BCLK rising edges.
  - Right slot (o_lrck=1): 0x0F0F; padding bits are 0.
  - Next frame: 0x8001 / 0x7FFE.
- Full: push 5 words back-to-back with FIFO_DEPTH=4 while IDLE -> o_ready=0 after the 4th; 5th held; accepted the cycle after the first pop; o_level=4 then 4.
- Underrun: prime 2 words, push nothing more -> frames 1-2 carry the data; frame 3 o_dacdat=0 throughout; o_underrun_cnt=1, then 2 after frame 4; o_lrck continues toggling every 512 clocks.
- Simultaneous: push on the same cycle as a frame load with 1 word queued -> o_level unchanged, correct word ordering, no underrun.
- Mid-frame reset: assert i_nrst=0 at k=20 -> outputs zero asynchronously, FIFO empty. After release the block waits in IDLE for PRIME words before emitting data.
